// File: rtl/debounce_sync.sv
// Synchronises a raw asynchronous input and filters it into a clean level q, with
// one-cycle rise/fall pulses whenever a new level has been held long enough.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   q_d, rise_d, fall_d;

  // Only sync[0] samples d_in; everything downstream sees the settled copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_in};
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign busy = (s != q);

  always_comb begin
    cnt_d  = '0;
    q_d    = q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != q) begin
      if (cnt_q == CntMax) begin
        q_d    = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q     <= q_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed and randomised checks of debounce_sync (default build and a one-cycle
// stability build) against a sliding-window model of the synchronised input.
module tb_debounce_sync;

  localparam int SYNC = 2;
  localparam int STA  = 8;
  localparam int STB  = 1;
  localparam int HMAX = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_a = 1'b0;
  logic d_b = 1'b0;
  logic q_a, rise_a, fall_a, busy_a;
  logic q_b, rise_b, fall_b, busy_b;

  int errors = 0;
  int checks = 0;

  // Model state: d_in seen at each edge since reset (1-based), plus model q per DUT.
  bit ha [0:HMAX];
  bit hb [0:HMAX];
  int n = 0;
  bit qa = 0, ra = 0, fa = 0, ba = 0;
  bit qb = 0, rb = 0, fb = 0, bb = 0;

  always #5 clk = ~clk;

  debounce_sync #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STA), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .d_in(d_a), .q(q_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
  );

  debounce_sync #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STB), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .d_in(d_b), .q(q_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Synchronised input as seen by the filter: d_in from SYNC edges earlier, 0 before reset exit.
  function automatic bit s_at(input int sel, input int idx);
    if (idx < 1) return 1'b0;
    return (sel == 0) ? ha[idx] : hb[idx];
  endfunction

  // q flips at edge n iff the last `st` filter inputs all differ from the current q.
  function automatic void step(input int sel, input int st, inout bit qm,
                               output bit r, output bit f, output bit b);
    bit flip = 1'b1;
    for (int k = n - SYNC - st + 1; k <= n - SYNC; k++) begin
      if (s_at(sel, k) == qm) flip = 1'b0;
    end
    r  = flip & ~qm;
    f  = flip & qm;
    qm = qm ^ flip;
    b  = (s_at(sel, n - SYNC + 1) != qm);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (n >= HMAX) begin
      $display("FAIL history overflow observed=%0d expected<%0d", n, HMAX);
      $fatal(1, "history overflow");
    end
    n++;
    ha[n] = d_a;
    hb[n] = d_b;
    step(0, STA, qa, ra, fa, ba);
    step(1, STB, qb, rb, fb, bb);
    #1;
    chk("a.q", q_a, qa);
    chk("a.rise", rise_a, ra);
    chk("a.fall", fall_a, fa);
    chk("a.busy", busy_a, ba);
    chk("b.q", q_b, qb);
    chk("b.rise", rise_b, rb);
    chk("b.fall", fall_b, fb);
    chk("b.busy", busy_b, bb);
    chk("a.rise_fall_excl", rise_a & fall_a, 1'b0);
    chk("b.rise_fall_excl", rise_b & fall_b, 1'b0);
  endtask

  // Assert reset between edges, check outputs clear before the next edge, release after 2 clocks.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, ".q"}, q_a, 1'b0);
    chk({tag, ".rise"}, rise_a, 1'b0);
    chk({tag, ".fall"}, fall_a, 1'b0);
    chk({tag, ".busy"}, busy_a, 1'b0);
    chk_int({tag, ".cnt"}, int'(u_a.cnt_q), 0);
    chk({tag, ".b.q"}, q_b, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    qa = 0; qb = 0;
  endtask

  initial begin
    int first;
    int nr, nf;
    bit saw_busy;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("por.q", q_a, 1'b0);
    chk("por.rise", rise_a, 1'b0);
    chk("por.fall", fall_a, 1'b0);
    chk("por.busy", busy_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    // 1: clean 0->1, q/rise on the 10th edge, rise gone on the 11th
    d_a = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 9) chk("t1.q_before", q_a, 1'b0);
      if (i == 10) begin
        chk("t1.q_at10", q_a, 1'b1);
        chk("t1.rise_at10", rise_a, 1'b1);
      end
      if (i == 11) chk("t1.rise_at11", rise_a, 1'b0);
    end
    repeat (3) tick();

    // Back to 0 for the glitch test
    d_a = 1'b0;
    repeat (12) tick();
    chk("t1b.q_low", q_a, 1'b0);

    // 2: 5-clock pulse is rejected, busy pulses then clears
    saw_busy = 0; nr = 0; nf = 0;
    d_a = 1'b1;
    repeat (5) begin tick(); saw_busy |= busy_a; nr += int'(rise_a); nf += int'(fall_a); end
    d_a = 1'b0;
    repeat (12) begin tick(); saw_busy |= busy_a; nr += int'(rise_a); nf += int'(fall_a); end
    chk("t2.saw_busy", saw_busy, 1'b1);
    chk("t2.busy_end", busy_a, 1'b0);
    chk("t2.q", q_a, 1'b0);
    chk_int("t2.rises", nr, 0);
    chk_int("t2.falls", nf, 0);

    // 3: bounce 1,0,1,0 at 2-clock spacing then hold 1
    nr = 0;
    for (int j = 0; j < 4; j++) begin
      d_a = (j % 2 == 0);
      repeat (2) begin tick(); nr += int'(rise_a); end
    end
    d_a = 1'b1;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      nr += int'(rise_a);
      if (first == 0 && q_a === 1'b1) first = i;
    end
    chk_int("t3.latency", first, 10);
    chk_int("t3.rise_count", nr, 1);

    // 4: 1->0 held, fall with q=0 on the 10th edge, no rise
    d_a = 1'b0;
    first = 0; nr = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      nr += int'(rise_a);
      if (first == 0 && fall_a === 1'b1) begin
        first = i;
        chk("t4.q_with_fall", q_a, 1'b0);
      end
    end
    chk_int("t4.latency", first, 10);
    chk_int("t4.rises", nr, 0);

    // 5: reset mid-count (cnt=5), then full latency again
    d_a = 1'b1;
    repeat (7) tick();
    chk_int("t5.cnt_before", int'(u_a.cnt_q), 5);
    async_reset("t5.rst");
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (first == 0 && rise_a === 1'b1) first = i;
    end
    chk_int("t5.latency", first, 10);

    // 6: one-cycle build follows d_in 3 edges later, one pulse per transition
    nr = 0; nf = 0;
    for (int j = 0; j < 6; j++) begin
      d_b = (j % 2 == 0);
      for (int i = 1; i <= 4; i++) begin
        tick();
        nr += int'(rise_b);
        nf += int'(fall_b);
        if (i == 3) chk("t6.q_follows", q_b, d_b);
      end
    end
    chk_int("t6.rises", nr, 3);
    chk_int("t6.falls", nf, 3);

    // Randomised runs on both builds
    async_reset("rnd.rst");
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) d_a = ~d_a;
      if ($urandom_range(0, 3) == 0) d_b = ~d_b;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
